// File: rtl/mem_arb_pkg.sv
// Shared types for the round-robin memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            any
);

    logic [NREQ-1:0] w_rot;
    logic [PW-1:0]   w_off;
    logic [PW:0]     w_sum;

    // Doubling the vector turns the wrap-around search into a plain lowest-bit search.
    assign w_rot = NREQ'({req, req} >> ptr);
    assign any   = |req;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = PW'(i);
        end
    end

    always_comb begin
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= (PW + 1)'(NREQ)) w_sum = w_sum - (PW + 1)'(NREQ);
        winner = w_sum[PW-1:0];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NREQ requesters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int DW   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_we,
    input  logic [NREQ-1:0][AW-1:0] req_addr,
    input  logic [NREQ-1:0][DW-1:0] req_wdata,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         done,
    output logic [DW-1:0]           rdata,
    output logic                    mem_re,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic                    mem_drive,
    output logic [DW-1:0]           mem_wdata,
    input  logic [DW-1:0]           mem_rdata
);

    localparam int PW = $clog2(NREQ);

    arb_state_t      r_state;
    logic [PW-1:0]   r_ptr;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [NREQ-1:0] r_grant;
    logic [DW-1:0]   r_rdata;

    logic [PW-1:0]   w_winner;
    logic [PW-1:0]   w_next_ptr;
    logic            w_any;
    logic            w_access;

    rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    assign w_next_ptr = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_grant <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_we    <= req_we[w_winner];
                        r_addr  <= req_addr[w_winner];
                        r_wdata <= req_wdata[w_winner];
                        r_grant <= NREQ'(1) << w_winner;
                        r_ptr   <= w_next_ptr;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!r_we) r_rdata <= mem_rdata;
                    r_state <= DONE;
                end
                DONE: begin
                    r_grant <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory controls decode straight from state, so an async reset mid-ACCESS drops
    // mem_we before the closing edge and no write commits.
    assign w_access  = (r_state == ACCESS);
    assign mem_re    = w_access & ~r_we;
    assign mem_we    = w_access & r_we;
    assign mem_drive = w_access & r_we;
    assign mem_addr  = w_access ? r_addr : '0;
    assign mem_wdata = (w_access & r_we) ? r_wdata : '0;

    assign grant = r_grant;
    assign done  = (r_state == DONE) ? r_grant : '0;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic vs a transaction-level model.
module tb_mem_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 4;

    logic                    clock;
    logic                    reset;
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         req_we;
    logic [NREQ-1:0][AW-1:0] req_addr;
    logic [NREQ-1:0][DW-1:0] req_wdata;
    logic [NREQ-1:0]         grant;
    logic [NREQ-1:0]         done;
    logic [DW-1:0]           rdata;
    logic                    mem_re;
    logic                    mem_we;
    logic [AW-1:0]           mem_addr;
    logic                    mem_drive;
    logic [DW-1:0]           mem_wdata;
    logic [DW-1:0]           mem_rdata;

    int checks   = 0;
    int failures = 0;
    int we_cycles = 0;
    logic mem_init;

    logic [DW-1:0] tb_mem  [0:255];
    logic [DW-1:0] ref_mem [0:255];

    mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .grant     (grant),
        .done      (done),
        .rdata     (rdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_drive (mem_drive),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[7:4] ^ a[3:0] ^ 4'h1;
    endfunction

    // Memory plus bus driver: write commits at the edge, bus shows memory on read, driver on write.
    always @(posedge clock) begin
        if (mem_init) begin
            for (int a = 0; a < 256; a++) tb_mem[a] <= init_val(8'(a));
        end else if (mem_we && mem_drive) begin
            tb_mem[mem_addr] <= mem_wdata;
        end
        if (mem_we) we_cycles <= we_cycles + 1;
    end

    assign mem_rdata = mem_re ? tb_mem[mem_addr] : (mem_drive ? mem_wdata : '0);

    task automatic set_req(input int idx, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        req_we[idx]    = we;
        req_addr[idx]  = addr;
        req_wdata[idx] = wdata;
        req[idx]       = 1'b1;
    endtask

    task automatic apply_reset();
        req   = '0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        mem_init = 1'b0;
        checks++; if (grant !== 4'b0)     begin failures++; $display("FAIL rst_grant: got %b expected 0", grant); end
        checks++; if (done !== 4'b0)      begin failures++; $display("FAIL rst_done: got %b expected 0", done); end
        checks++; if (rdata !== 4'h0)     begin failures++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
        checks++; if (mem_re !== 1'b0)    begin failures++; $display("FAIL rst_mem_re: got %b expected 0", mem_re); end
        checks++; if (mem_we !== 1'b0)    begin failures++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 8'h0)  begin failures++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_drive !== 1'b0) begin failures++; $display("FAIL rst_mem_drive: got %b expected 0", mem_drive); end
        checks++; if (mem_wdata !== 4'h0) begin failures++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        int w0;
        w0 = we_cycles;
        set_req(2, 1'b1, 8'h10, 4'hA);
        @(negedge clock);
        checks++; if (grant !== 4'b0100)  begin failures++; $display("FAIL wr_grant: got %b expected 0100", grant); end
        checks++; if (mem_we !== 1'b1 || mem_drive !== 1'b1 || mem_re !== 1'b0)
            begin failures++; $display("FAIL wr_ctrl: got we=%b drive=%b re=%b expected 1 1 0", mem_we, mem_drive, mem_re); end
        checks++; if (mem_addr !== 8'h10 || mem_wdata !== 4'hA)
            begin failures++; $display("FAIL wr_bus: got addr=%h data=%h expected 10 a", mem_addr, mem_wdata); end
        checks++; if (done !== 4'b0)      begin failures++; $display("FAIL wr_done_early: got %b expected 0", done); end
        @(negedge clock);
        checks++; if (done !== 4'b0100 || grant !== 4'b0100)
            begin failures++; $display("FAIL wr_done: got done=%b grant=%b expected 0100 0100", done, grant); end
        checks++; if (mem_we !== 1'b0)    begin failures++; $display("FAIL wr_we_off: got %b expected 0", mem_we); end
        req[2] = 1'b0;
        @(negedge clock);
        checks++; if (grant !== 4'b0 || done !== 4'b0)
            begin failures++; $display("FAIL wr_idle: got grant=%b done=%b expected 0 0", grant, done); end
        checks++; if (we_cycles - w0 !== 1) begin failures++; $display("FAIL wr_we_cycles: got %0d expected 1", we_cycles - w0); end
        checks++; if (tb_mem[8'h10] !== 4'hA) begin failures++; $display("FAIL wr_commit: got %h expected a", tb_mem[8'h10]); end
        set_req(2, 1'b0, 8'h10, 4'h0);
        @(negedge clock);
        checks++; if (mem_re !== 1'b1 || mem_drive !== 1'b0 || mem_addr !== 8'h10)
            begin failures++; $display("FAIL rd_ctrl: got re=%b drive=%b addr=%h expected 1 0 10", mem_re, mem_drive, mem_addr); end
        @(negedge clock);
        checks++; if (done !== 4'b0100)   begin failures++; $display("FAIL rd_done: got %b expected 0100", done); end
        checks++; if (rdata !== 4'hA)     begin failures++; $display("FAIL rd_data: got %h expected a", rdata); end
        req[2] = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_all_four();
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 8'(8'h40 + i), 4'h0);
        for (int k = 0; k < NREQ; k++) begin
            @(negedge clock);
            checks++; if (grant !== 4'(1 << k)) begin failures++; $display("FAIL rr_grant%0d: got %b expected %b", k, grant, 4'(1 << k)); end
            checks++; if (done !== 4'b0) begin failures++; $display("FAIL rr_done_early%0d: got %b expected 0", k, done); end
            @(negedge clock);
            checks++; if (done !== 4'(1 << k)) begin failures++; $display("FAIL rr_done%0d: got %b expected %b", k, done, 4'(1 << k)); end
            checks++; if (rdata !== init_val(8'(8'h40 + k)))
                begin failures++; $display("FAIL rr_rdata%0d: got %h expected %h", k, rdata, init_val(8'(8'h40 + k))); end
            req[k] = 1'b0;
            @(negedge clock);
            checks++; if (grant !== 4'b0 || done !== 4'b0)
                begin failures++; $display("FAIL rr_idle%0d: got grant=%b done=%b expected 0 0", k, grant, done); end
        end
    endtask

    task automatic test_pointer_wrap();
        set_req(1, 1'b0, 8'h50, 4'h0);
        set_req(3, 1'b0, 8'h53, 4'h0);
        @(negedge clock);
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL wrap_first: got %b expected 0010", grant); end
        @(negedge clock);
        checks++; if (rdata !== init_val(8'h50)) begin failures++; $display("FAIL wrap_rdata1: got %h expected %h", rdata, init_val(8'h50)); end
        req[1] = 1'b0;
        @(negedge clock);
        set_req(0, 1'b0, 8'h52, 4'h0);
        @(negedge clock);
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL wrap_second: got %b expected 1000", grant); end
        @(negedge clock);
        checks++; if (done !== 4'b1000 || rdata !== init_val(8'h53))
            begin failures++; $display("FAIL wrap_done3: got done=%b rdata=%h expected 1000 %h", done, rdata, init_val(8'h53)); end
        req[3] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL wrap_third: got %b expected 0001", grant); end
        @(negedge clock);
        req[0] = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_mid_change();
        set_req(1, 1'b1, 8'h30, 4'h6);
        @(negedge clock);
        req_addr[1]  = 8'h31;
        req_wdata[1] = 4'h9;
        req[1]       = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h30 || mem_wdata !== 4'h6)
            begin failures++; $display("FAIL mid_latch: got we=%b addr=%h data=%h expected 1 30 6", mem_we, mem_addr, mem_wdata); end
        @(negedge clock);
        checks++; if (done !== 4'b0010) begin failures++; $display("FAIL mid_done: got %b expected 0010", done); end
        @(negedge clock);
        checks++; if (tb_mem[8'h30] !== 4'h6) begin failures++; $display("FAIL mid_mem30: got %h expected 6", tb_mem[8'h30]); end
        checks++; if (tb_mem[8'h31] !== init_val(8'h31))
            begin failures++; $display("FAIL mid_mem31: got %h expected %h", tb_mem[8'h31], init_val(8'h31)); end
    endtask

    task automatic test_reset_mid_access();
        set_req(2, 1'b1, 8'h20, 4'h5);
        @(negedge clock);
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rma_we_before: got %b expected 1", mem_we); end
        reset = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0 || mem_drive !== 1'b0 || grant !== 4'b0)
            begin failures++; $display("FAIL rma_clear: got we=%b drive=%b grant=%b expected 0 0 0", mem_we, mem_drive, grant); end
        req[2] = 1'b0;
        @(negedge clock);
        checks++; if (done !== 4'b0) begin failures++; $display("FAIL rma_no_done: got %b expected 0", done); end
        checks++; if (tb_mem[8'h20] !== 4'h3) begin failures++; $display("FAIL rma_mem: got %h expected 3", tb_mem[8'h20]); end
        reset = 1'b0;
        set_req(3, 1'b0, 8'h21, 4'h0);
        set_req(0, 1'b0, 8'h20, 4'h0);
        @(negedge clock);
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rma_grant0: got %b expected 0001", grant); end
        @(negedge clock);
        checks++; if (done !== 4'b0001 || rdata !== 4'h3)
            begin failures++; $display("FAIL rma_read: got done=%b rdata=%h expected 0001 3", done, rdata); end
        req[0] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL rma_grant3: got %b expected 1000", grant); end
        @(negedge clock);
        checks++; if (rdata !== init_val(8'h21)) begin failures++; $display("FAIL rma_read21: got %h expected %h", rdata, init_val(8'h21)); end
        req[3] = 1'b0;
        @(negedge clock);
    endtask

    // Transaction-level model: winner by modular search from the pointer, fixed 3-cycle timing.
    task automatic test_random();
        int   m_start, m_win, m_ptr, mism;
        logic m_we;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata, m_rdata, m_txn_rdata;
        logic [NREQ-1:0] exp_grant, exp_done;
        bit   in_acc, in_done, found;
        apply_reset();
        for (int a = 0; a < 256; a++) ref_mem[a] = tb_mem[a];
        m_start = -10; m_win = 0; m_ptr = 0; m_we = 1'b0; m_addr = '0;
        m_wdata = '0; m_rdata = '0; m_txn_rdata = '0;
        for (int c = 0; c < 1000; c++) begin
            in_acc    = (c == m_start);
            in_done   = (c == m_start + 1);
            exp_grant = (in_acc || in_done) ? 4'(1 << m_win) : 4'b0;
            exp_done  = in_done ? exp_grant : 4'b0;
            if (in_done && !m_we) m_rdata = m_txn_rdata;
            checks++; if (grant !== exp_grant) begin failures++; $display("FAIL rnd_grant c=%0d: got %b expected %b", c, grant, exp_grant); end
            checks++; if (done !== exp_done) begin failures++; $display("FAIL rnd_done c=%0d: got %b expected %b", c, done, exp_done); end
            checks++; if (mem_re !== (in_acc && !m_we)) begin failures++; $display("FAIL rnd_re c=%0d: got %b expected %b", c, mem_re, in_acc && !m_we); end
            checks++; if (mem_we !== (in_acc && m_we)) begin failures++; $display("FAIL rnd_we c=%0d: got %b expected %b", c, mem_we, in_acc && m_we); end
            checks++; if (mem_drive !== (in_acc && m_we)) begin failures++; $display("FAIL rnd_drive c=%0d: got %b expected %b", c, mem_drive, in_acc && m_we); end
            checks++; if (rdata !== m_rdata) begin failures++; $display("FAIL rnd_rdata c=%0d: got %h expected %h", c, rdata, m_rdata); end
            checks++; if ((mem_re & mem_drive) !== 1'b0) begin failures++; $display("FAIL rnd_bus_excl c=%0d: got re=%b drive=%b", c, mem_re, mem_drive); end
            checks++; if (!$onehot0(done)) begin failures++; $display("FAIL rnd_done_onehot c=%0d: got %b", c, done); end
            if (in_acc) begin
                checks++; if (mem_addr !== m_addr) begin failures++; $display("FAIL rnd_addr c=%0d: got %h expected %h", c, mem_addr, m_addr); end
                if (m_we) begin
                    checks++; if (mem_wdata !== m_wdata) begin failures++; $display("FAIL rnd_wdata c=%0d: got %h expected %h", c, mem_wdata, m_wdata); end
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (done[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 4'($urandom));
                end
            end
            if (in_acc) begin
                req_addr[m_win]  = 8'($urandom);
                req_wdata[m_win] = 4'($urandom);
            end
            if (c + 1 >= m_start + 3 && req != '0) begin
                found = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && req[(m_ptr + k) % NREQ]) begin
                        found = 1'b1;
                        m_win = (m_ptr + k) % NREQ;
                    end
                end
                m_start = c + 1;
                m_we    = req_we[m_win];
                m_addr  = req_addr[m_win];
                m_wdata = req_wdata[m_win];
                m_ptr   = (m_win + 1) % NREQ;
                if (m_we) ref_mem[m_addr] = m_wdata;
                else      m_txn_rdata = ref_mem[m_addr];
            end
            @(negedge clock);
        end
        req = '0;
        repeat (3) @(negedge clock);
        mism = 0;
        for (int a = 0; a < 256; a++) if (tb_mem[a] !== ref_mem[a]) mism++;
        checks++; if (mism != 0) begin failures++; $display("FAIL rnd_mem_image: got %0d differing words expected 0", mism); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clock     = 1'b0;
        reset     = 1'b1;
        mem_init  = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        test_reset();
        test_write_read();
        test_all_four();
        test_pointer_wrap();
        test_mid_change();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one single-port `Memory` instance among `NREQ` requesters. It sits between the requesters and the memory plus its data-bus `BusDriver`. It accepts one transaction at a time, sequences the memory's `re`, `we`, `addr` and bus-drive controls through a three-state FSM, returns read data, and pulses a per-requester `done`. Fairness is strict round-robin on the last granted index.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `AW`, 8: memory address width.
- `DW`, 4: memory data width.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  `[NREQ-1:0]`  request, one bit per requester; held until that requester's `done`.
- `req_we`  in  `[NREQ-1:0]`  1 = write, 0 = read.
- `req_addr`  in  `[NREQ-1:0][AW-1:0]`  address per requester.
- `req_wdata`  in  `[NREQ-1:0][DW-1:0]`  write data per requester.
- `grant`  out  `[NREQ-1:0]`  one-hot owner of the current transaction; 0 in IDLE.
- `done`  out  `[NREQ-1:0]`  one-cycle completion pulse to the owner.
- `rdata`  out  `DW`  registered read data; valid while `done` is high.
- `mem_re`  out  1  memory read enable.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  `AW`  memory address.
- `mem_drive`  out  1  `BusDriver` enable.
- `mem_wdata`  out  `DW`  `BusDriver` data.
- `mem_rdata`  in  `DW`  `BusDriver` buffer, i.e. the bus value.

## Operation
- **State reset values:** FSM state IDLE, round-robin pointer `ptr` = 0.
- **Output reset values:** `grant`, `done`, `rdata`, `mem_re`, `mem_we`, `mem_addr`, `mem_drive` and `mem_wdata` are all 0.
- **IDLE:**
  - If `req` is nonzero, pick the winner `w`: the first set bit searching `ptr`, `ptr+1`, …, wrapping modulo `NREQ`.
  - At the clock edge, latch `w`'s `req_we`, `req_addr` and `req_wdata` into internal registers, set `grant` to one-hot `w`, set `ptr` to `(w+1) mod NREQ`, and go to ACCESS.
  - If `req` is zero, stay in IDLE.
- **ACCESS (exactly 1 cycle):**
  - `mem_addr` is the latched address.
  - Write: `mem_we`=1, `mem_drive`=1, `mem_wdata` = latched data, `mem_re`=0. The memory commits the write at the closing edge.
  - Read: `mem_re`=1, `mem_drive`=0, `mem_we`=0. `rdata` captures `mem_rdata` at the closing edge.
  - Then go to DONE.
- **DONE (exactly 1 cycle):**
  - `done[w]`=1 and `grant` is still `w`.
  - All `mem_*` enables are 0.
  - Then go to IDLE and clear `grant`.
- **Invariants:**
  - `mem_re` and `mem_drive` are never both 1.
  - `mem_re`, `mem_we` and `mem_drive` are 0 outside ACCESS.
  - `done` has at most one bit set, and only in DONE.
- **Requester inputs during a transaction:** ignored after the latch. If a requester drops `req` mid-transaction, the transaction still completes. There is no abort.
- **Requester after `done`:** it must drop `req` by the next edge. A `req` still high in IDLE is treated as a new request and arbitrated normally.
- **`rdata`:** holds its value until the next read completes. Writes do not change it.

## Timing
- **Latency:** `req` sampled at edge T0 (in IDLE) → ACCESS during cycle T0+1 → `done` during cycle T0+2 → IDLE at T0+3.
- **Throughput:** one transaction per 3 cycles under continuous requests.
- **Arbitration inputs:** the decision uses `req` sampled in IDLE only. Simultaneous requests are resolved purely by `ptr`.
- **Reset asserted mid-ACCESS:** outputs clear asynchronously, so `mem_we` drops before the edge and no write commits. The FSM returns to IDLE with `ptr` = 0.
- **Reset deassertion:** the first request can be sampled at the first rising edge after `reset` falls.

## Structure
- **Package `mem_arb_pkg`:** FSM state enum `arb_state_t` {IDLE, ACCESS, DONE}.
- **Sub-module `rr_picker`:** combinational; inputs `req` and `ptr`; outputs `winner` index and `any`. Implemented as a doubled-vector priority search.
- **Top level:** FSM, latch registers, output decode.

## Test plan
- **Single write then read:** `req[2]` write addr 0x10 data 0xA; after `done[2]`, `req[2]` read 0x10 → `rdata`=0xA with `done[2]` exactly 2 cycles after the sample edge. `mem_we` is high for exactly one cycle.
- **All four requesting from reset:** all four hold reads of distinct addresses → grants in order 0, 1, 2, 3, each `done` 3 cycles apart. No requester is granted twice before the others.
- **Pointer wrap:** after a grant to 3, requests from 1 and 3 together → 1 wins. Then `req[0]` and `req[3]` together → 3 wins.
- **Input change mid-transaction:** change `req_addr` and `req_wdata` of the owner during ACCESS → the memory receives the latched values. Dropping `req` during ACCESS still yields `done`.
- **Reset mid-ACCESS:** write 0x5 to addr 0x20 (previously 0x3) and assert `reset` during ACCESS → no `done`, and a later read of 0x20 returns 0x3. After reset, `grant` starts at requester 0.
- **Bus exclusivity checker:** run random traffic for 1000 cycles → `mem_re & mem_drive` never true, and `done` is always one-hot or zero.
